// File: rtl/iarray_pkg.sv
// Shared definitions for the iarray 2RW wrapper: clear-engine state encoding,
// read pipeline depth limit and the even-parity helper.
package iarray_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CLR  = 1'b1
    } clr_state_e;

    localparam int RDLAT_MAX = 3;
    localparam int PAR_MAXW  = 256;

    // Callers zero-extend their word to PAR_MAXW; zero bits do not change the parity.
    function automatic logic par_even(input logic [PAR_MAXW-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/iarray_2rw_pipe_if.sv
// Two-port access bundle for iarray_2rw_pipe: addresses, enables, data,
// read-valid/parity status and the clear/busy/collision side signals.
interface iarray_2rw_pipe_if #(
    parameter int ADDRBIT = 6,
    parameter int WIDTH   = 80
);
    logic [ADDRBIT-1:0] a0, a1;
    logic               we0, we1;
    logic               re0, re1;
    logic [WIDTH-1:0]   di0, di1;
    logic [WIDTH-1:0]   do0, do1;
    logic               vld0, vld1;
    logic               perr0, perr1;
    logic               clr;
    logic               busy;
    logic               col;
    logic               test, mask;

    modport master (
        output a0, a1, we0, we1, re0, re1, di0, di1, clr, test, mask,
        input  do0, do1, vld0, vld1, perr0, perr1, busy, col
    );

    modport slave (
        input  a0, a1, we0, we1, re0, re1, di0, di1, clr, test, mask,
        output do0, do1, vld0, vld1, perr0, perr1, busy, col
    );
endinterface

// File: rtl/iarray_clr_fsm.sv
// Clear engine: walks port A over every word after reset or on clr, and
// holds busy while doing so.
module iarray_clr_fsm
    import iarray_pkg::*;
#(
    parameter int ADDRBIT = 6,
    parameter int DEPTH   = 48
) (
    input  logic               clk0,
    input  logic               p0rst_,
    input  logic               clr,
    output logic               busy,
    output logic               clr_we,
    output logic [ADDRBIT-1:0] clr_addr
);

    localparam logic [ADDRBIT-1:0] LAST = ADDRBIT'(DEPTH - 1);

    clr_state_e         state_q, state_d;
    logic [ADDRBIT-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                // A fresh request restarts the sweep; the current word is still written.
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLR;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_addr = cnt_q;

    always_ff @(posedge clk0 or negedge p0rst_) begin
        if (!p0rst_) begin
            state_q <= ST_CLR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/iarray_2rw_pipe.sv
// True dual-port array wrapper with registered, RDLAT-deep read pipes, write
// forwarding, collision flag and clear engine. Optional: IARRAY_PARITY_EN.
module iarray_2rw_pipe
    import iarray_pkg::*;
#(
    parameter int               ADDRBIT  = 6,
    parameter int               DEPTH    = 48,
    parameter int               WIDTH    = 80,
    parameter int               RDLAT    = 1,
    parameter int               WRFWD    = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input logic              clk0,
    input logic              p0rst_,
    iarray_2rw_pipe_if.slave bus
);

`ifdef IARRAY_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif
    localparam int NSTG = (RDLAT > RDLAT_MAX) ? RDLAT_MAX : ((RDLAT < 1) ? 1 : RDLAT);
    localparam logic [ADDRBIT:0] DEPTH_X = (ADDRBIT + 1)'(DEPTH);

    function automatic logic [MW-1:0] encode(input logic [WIDTH-1:0] d);
`ifdef IARRAY_PARITY_EN
        return {par_even(PAR_MAXW'(d)), d};
`else
        return d;
`endif
    endfunction

    // Returns {parity_error, data} for a stored word.
    function automatic logic [WIDTH:0] ram_word(input logic [MW-1:0] w);
`ifdef IARRAY_PARITY_EN
        return {w[WIDTH] != par_even(PAR_MAXW'(w[WIDTH-1:0])), w[WIDTH-1:0]};
`else
        return {1'b0, w};
`endif
    endfunction

    logic [MW-1:0]      ram_q [DEPTH];

    logic               busy, clr_we;
    logic [ADDRBIT-1:0] clr_addr;

    logic               wr_blk, rng0, rng1, uwe0, uwe1, same_addr, collide;
    logic               wea, web;
    logic [ADDRBIT-1:0] waa;
    logic [MW-1:0]      wda, wdb;
    logic [WIDTH:0]     ram_rd0, ram_rd1;
    logic [1:0]         rok, rper;
    logic [WIDTH-1:0]   rdat [2];

    logic [WIDTH-1:0]   dat_q [2][NSTG+1];
    logic [WIDTH-1:0]   dat_d [2][NSTG+1];
    logic [NSTG:0]      vld_q [2];
    logic [NSTG:0]      vld_d [2];
    logic [NSTG:0]      per_q [2];
    logic [NSTG:0]      per_d [2];
    logic               col_q, col_d;

    iarray_clr_fsm #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH)
    ) u_clr_fsm (
        .clk0     (clk0),
        .p0rst_   (p0rst_),
        .clr      (bus.clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Access qualification, write arbitration and read-data selection
    always_comb begin
        wr_blk    = bus.test & bus.mask;
        rng0      = {1'b0, bus.a0} < DEPTH_X;
        rng1      = {1'b0, bus.a1} < DEPTH_X;
        uwe0      = bus.we0 & ~busy & ~wr_blk & rng0;
        uwe1      = bus.we1 & ~busy & ~wr_blk & rng1;
        same_addr = (bus.a0 == bus.a1);
        collide   = uwe0 & uwe1 & same_addr;

        wea = clr_we | uwe0;
        waa = clr_we ? clr_addr : bus.a0;
        wda = clr_we ? encode(INIT_VAL) : encode(bus.di0);
        web = uwe1 & ~collide;
        wdb = encode(bus.di1);

        rok[0] = bus.re0 & ~busy;
        rok[1] = bus.re1 & ~busy;

        ram_rd0 = rng0 ? ram_word(ram_q[bus.a0]) : '0;
        ram_rd1 = rng1 ? ram_word(ram_q[bus.a1]) : '0;

        // Forwarded words come straight from di, so they never flag parity.
        rdat[0] = ram_rd0[WIDTH-1:0];
        rper[0] = ram_rd0[WIDTH];
        if (uwe0) begin
            rdat[0] = bus.di0;
            rper[0] = 1'b0;
        end else if ((WRFWD != 0) && web && same_addr) begin
            rdat[0] = bus.di1;
            rper[0] = 1'b0;
        end

        rdat[1] = ram_rd1[WIDTH-1:0];
        rper[1] = ram_rd1[WIDTH];
        if (web) begin
            rdat[1] = bus.di1;
            rper[1] = 1'b0;
        end else if ((WRFWD != 0) && uwe0 && same_addr) begin
            rdat[1] = bus.di0;
            rper[1] = 1'b0;
        end

        col_d = collide;
    end

    always_ff @(posedge clk0) begin
        if (wea) ram_q[waa] <= wda;
        if (web) ram_q[bus.a1] <= wdb;
    end

    // Stage 0 models the primitive output register; stages 1..NSTG are output stages.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            vld_d[p][0] = rok[p];
            dat_d[p][0] = rok[p] ? rdat[p] : dat_q[p][0];
            per_d[p][0] = rok[p] & rper[p];
            for (int s = 1; s <= NSTG; s++) begin
                vld_d[p][s] = vld_q[p][s-1];
                dat_d[p][s] = vld_q[p][s-1] ? dat_q[p][s-1] : dat_q[p][s];
                per_d[p][s] = vld_q[p][s-1] & per_q[p][s-1];
            end
        end
    end

    always_ff @(posedge clk0 or negedge p0rst_) begin
        if (!p0rst_) begin
            for (int p = 0; p < 2; p++) begin
                vld_q[p] <= '0;
                per_q[p] <= '0;
                for (int s = 0; s <= NSTG; s++) begin
                    dat_q[p][s] <= '0;
                end
            end
            col_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            per_q <= per_d;
            dat_q <= dat_d;
            col_q <= col_d;
        end
    end

    assign bus.do0   = dat_q[0][NSTG];
    assign bus.do1   = dat_q[1][NSTG];
    assign bus.vld0  = vld_q[0][NSTG];
    assign bus.vld1  = vld_q[1][NSTG];
    assign bus.perr0 = per_q[0][NSTG];
    assign bus.perr1 = per_q[1][NSTG];
    assign bus.busy  = busy;
    assign bus.col   = col_q;

endmodule

// File: tb/tb_iarray_2rw_pipe.sv
// Directed bench for iarray_2rw_pipe: two instances (forwarding on/off),
// both RDLAT=2, driven with identical stimulus.
module tb_iarray_2rw_pipe;

    logic        clk0 = 1'b0;
    logic        p0rst_ = 1'b1;
    logic [5:0]  a0, a1;
    logic        we0, we1, re0, re1, clr, test, mask;
    logic [79:0] di0, di1;

    int vec_cnt = 0;
    int miscmp  = 0;

    iarray_2rw_pipe_if #(.ADDRBIT(6), .WIDTH(80)) bf ();
    iarray_2rw_pipe_if #(.ADDRBIT(6), .WIDTH(80)) bo ();

    assign bf.a0 = a0;   assign bo.a0 = a0;
    assign bf.a1 = a1;   assign bo.a1 = a1;
    assign bf.we0 = we0; assign bo.we0 = we0;
    assign bf.we1 = we1; assign bo.we1 = we1;
    assign bf.re0 = re0; assign bo.re0 = re0;
    assign bf.re1 = re1; assign bo.re1 = re1;
    assign bf.di0 = di0; assign bo.di0 = di0;
    assign bf.di1 = di1; assign bo.di1 = di1;
    assign bf.clr = clr; assign bo.clr = clr;
    assign bf.test = test; assign bo.test = test;
    assign bf.mask = mask; assign bo.mask = mask;

    iarray_2rw_pipe #(.RDLAT(2), .WRFWD(1)) dut_f (.clk0(clk0), .p0rst_(p0rst_), .bus(bf));
    iarray_2rw_pipe #(.RDLAT(2), .WRFWD(0)) dut_o (.clk0(clk0), .p0rst_(p0rst_), .bus(bo));

    always #5 clk0 = ~clk0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk0);
    endtask

    task automatic idle_in();
        a0 = '0; a1 = '0; we0 = 0; we1 = 0; re0 = 0; re1 = 0;
        di0 = '0; di1 = '0; clr = 0; test = 0; mask = 0;
    endtask

    task automatic wr(input int p, input logic [5:0] ad, input logic [79:0] d);
        if (p == 0) begin we0 = 1; a0 = ad; di0 = d; end
        else        begin we1 = 1; a1 = ad; di1 = d; end
        tick();
        we0 = 0; we1 = 0;
    endtask

    // Read on dut_f, expect nothing two cycles after re and {vld,perr,do} three cycles after.
    task automatic rd_chk(input int p, input logic [5:0] ad, input logic [79:0] exp, input string tag);
        if (p == 0) begin re0 = 1; a0 = ad; end
        else        begin re1 = 1; a1 = ad; end
        tick();
        re0 = 0; re1 = 0;
        tick();
        chk_vec({tag, "_early"}, 128'((p == 0) ? bf.vld0 : bf.vld1), 128'(0));
        tick();
        if (p == 0) chk_vec(tag, 128'({bf.vld0, bf.perr0, bf.do0}), 128'({2'b10, exp}));
        else        chk_vec(tag, 128'({bf.vld1, bf.perr1, bf.do1}), 128'({2'b10, exp}));
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bf.busy === 1'b1 && n < 300) begin
            n++;
            tick();
        end
    endtask

    int  n;
    logic saw;

    initial begin
        idle_in();
        #2 p0rst_ = 1'b0;
        #1;
        chk_vec("rst_do", 128'({bf.do0, bf.do1}), 128'(0));
        chk_vec("rst_flags", 128'({bf.vld0, bf.vld1, bf.col, bf.perr0, bf.perr1, bf.busy}), 128'(6'b000001));
        repeat (2) tick();
        p0rst_ = 1'b1;
        count_busy(n);
        chk_vec("init_busy_len", 128'(n), 128'(48));

        // Back-to-back reads of the whole array right after the initial clear
        for (int k = 0; k < 51; k++) begin
            if (k >= 3) chk_vec("init_rd", 128'({bf.vld1, bf.do1}), 128'({1'b1, 80'h0}));
            if (k < 48) begin re1 = 1; a1 = 6'(k); end
            else        re1 = 0;
            tick();
        end
        chk_vec("b2b_tail_vld", 128'(bf.vld1), 128'(0));

        wr(0, 6'd5, 80'hA5);
        rd_chk(1, 6'd5, 80'hA5, "xport_rd");

        // Write-write collision on the same address
        we0 = 1; a0 = 6'd7; di0 = 80'd1;
        we1 = 1; a1 = 6'd7; di1 = 80'd2;
        tick();
        we0 = 0; we1 = 0;
        chk_vec("col_pulse", 128'(bf.col), 128'(1));
        tick();
        chk_vec("col_clear", 128'(bf.col), 128'(0));
        rd_chk(0, 6'd7, 80'd1, "col_winner");

        // Cross-port forwarding: port A writes while port B reads the same word
        wr(0, 6'd9, 80'h55);
        we0 = 1; a0 = 6'd9; di0 = 80'd3;
        re1 = 1; a1 = 6'd9;
        tick();
        we0 = 0; re1 = 0;
        repeat (2) tick();
        chk_vec("fwd_on", 128'({bf.vld1, bf.do1}), 128'({1'b1, 80'd3}));
        chk_vec("fwd_off", 128'({bo.vld1, bo.do1}), 128'({1'b1, 80'h55}));
        rd_chk(1, 6'd9, 80'd3, "fwd_after");
        chk_vec("fwd_off_after", 128'(bo.do1), 128'(3));

        // Same-port write-first
        we1 = 1; re1 = 1; a1 = 6'd11; di1 = 80'hBEEF;
        tick();
        we1 = 0; re1 = 0;
        repeat (2) tick();
        chk_vec("wfirst_f", 128'({bf.vld1, bf.do1}), 128'({1'b1, 80'hBEEF}));
        chk_vec("wfirst_o", 128'({bo.vld1, bo.do1}), 128'({1'b1, 80'hBEEF}));
        tick();
        chk_vec("do_hold", 128'({bf.vld1, bf.do1}), 128'({1'b0, 80'hBEEF}));

        // Out-of-range: writes dropped, no collision, read returns zero with vld
        we0 = 1; a0 = 6'd50; di0 = 80'd77;
        we1 = 1; a1 = 6'd50; di1 = 80'd88;
        tick();
        we0 = 0; we1 = 0;
        chk_vec("oor_no_col", 128'(bf.col), 128'(0));
        rd_chk(1, 6'd50, 80'h0, "oor_rd");

        test = 1; mask = 1;
        wr(0, 6'd12, 80'd66);
        mask = 0;
        wr(1, 6'd13, 80'h99);
        test = 0;
        rd_chk(0, 6'd12, 80'h0, "wr_blocked");
        rd_chk(0, 6'd13, 80'h99, "wr_test_only");

        wr(1, 6'd47, 80'h8000_0123_4567_89AB_CDEF);
        rd_chk(0, 6'd47, 80'h8000_0123_4567_89AB_CDEF, "wide_word");

        // Clear during traffic, re-requested part way through
        clr = 1;
        tick();
        clr = 0;
        chk_vec("clr_busy", 128'(bf.busy), 128'(1));
        saw = 0;
        n = 0;
        while (bf.busy === 1'b1 && n < 300) begin
            n++;
            if (bf.vld0 !== 1'b0) saw = 1;
            clr = (n == 10);
            re0 = 1; a0 = 6'(n % 48);
            we1 = 1; a1 = 6'd20; di1 = 80'h1234;
            tick();
        end
        clr = 0; re0 = 0; we1 = 0;
        repeat (3) begin
            if (bf.vld0 !== 1'b0) saw = 1;
            tick();
        end
        chk_vec("busy_no_vld", 128'(saw), 128'(0));
        chk_vec("reclr_busy_len", 128'(n), 128'(58));
        rd_chk(1, 6'd5, 80'h0, "clr_a5");
        rd_chk(0, 6'd7, 80'h0, "clr_a7");
        rd_chk(1, 6'd11, 80'h0, "clr_a11");
        rd_chk(0, 6'd47, 80'h0, "clr_a47");
        rd_chk(0, 6'd20, 80'h0, "clr_a20");

        // Reset in the middle of a clear
        wr(0, 6'd3, 80'hC3);
        rd_chk(0, 6'd3, 80'hC3, "pre_rst");
        clr = 1;
        tick();
        clr = 0;
        repeat (5) tick();
        chk_vec("hold_busy", 128'(bf.do0), 128'(80'hC3));
        #2 p0rst_ = 1'b0;
        #1;
        chk_vec("midrst_do", 128'(bf.do0), 128'(0));
        chk_vec("midrst_busy", 128'(bf.busy), 128'(1));
        tick();
        p0rst_ = 1'b1;
        count_busy(n);
        chk_vec("midrst_busy_len", 128'(n), 128'(48));
        rd_chk(0, 6'd3, 80'h0, "post_rst_a3");

`ifdef IARRAY_PARITY_EN
        dut_f.ram_q[3] = 81'h1;
        re0 = 1; a0 = 6'd3;
        tick();
        re0 = 0;
        repeat (2) tick();
        chk_vec("perr_flag", 128'({bf.vld0, bf.perr0}), 128'(2'b11));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
